// File: rtl/screen_state_sequencer_if.sv
// Pixel bus between the sprite/palette sources and the screen sequencer.
// The sequencer (slave) consumes three candidate pixels plus sprite coverage
// flags and returns the selected, registered output pixel.
interface screen_state_sequencer_if;
  logic [11:0] game_rgb;
  logic [11:0] title_rgb;
  logic        title_on;
  logic [11:0] gameover_rgb;
  logic        gameover_on;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;

  // Pixel sources side: drives candidates, observes the final pixel.
  modport master (
    output game_rgb,
    output title_rgb,
    output title_on,
    output gameover_rgb,
    output gameover_on,
    input  red,
    input  green,
    input  blue
  );

  // Sequencer side.
  modport slave (
    input  game_rgb,
    input  title_rgb,
    input  title_on,
    input  gameover_rgb,
    input  gameover_on,
    output red,
    output green,
    output blue
  );
endinterface

// File: rtl/screen_state_sequencer.sv
// Screen/overlay controller for the VGA pipeline.
// Walks the game through TITLE -> PLAY -> DYING -> OVER -> TITLE, counts frames
// to time the death animation, the game-over blink and the restart hold-off,
// and picks which source drives each output pixel (one cycle of latency).
// Optional build macro SCREEN_FADE_EN: progressive dimming during DYING
// (shift grows by one every FADE_STEP frames, capped at 3); otherwise DYING
// uses a fixed shift of 1 and FADE_STEP is unused.
module screen_state_sequencer #(
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned HOLD_FRAMES  = 90,
  parameter int unsigned FADE_STEP    = 15
) (
  input  logic                     vga_clk,
  input  logic                     reset_n,
  input  logic                     frame_start,
  input  logic                     start_btn,
  input  logic                     restart_btn,
  input  logic                     player_dead,
  screen_state_sequencer_if.slave  pix,
  output logic [1:0]               state,
  output logic                     game_active,
  output logic                     clear_game
);

  typedef enum logic [1:0] {
    StTitle = 2'd0,
    StPlay  = 2'd1,
    StDying = 2'd2,
    StOver  = 2'd3
  } state_e;

  localparam logic [7:0] DeathLast = 8'(DEATH_FRAMES - 1);
  localparam logic [7:0] HoldMin   = 8'(HOLD_FRAMES);
  localparam logic [8:0] BlinkLen  = 9'(BLINK_FRAMES);

  state_e      state_q, state_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        blink_q, blink_d;
  logic        start_q, restart_q;
  logic        clear_q, clear_d;
  logic        active_q;
  logic [11:0] rgb_q, rgb_d;

  logic        start_edge, restart_edge;
  logic [8:0]  cnt_plus1;
  logic        blink_hit;
  logic [1:0]  dim_shift;

  // Scale each 4-bit channel down by the same right shift.
  function automatic logic [11:0] dim_rgb(input logic [11:0] rgb, input logic [1:0] sh);
    logic [3:0] r, g, b;
    r = rgb[11:8] >> sh;
    g = rgb[7:4] >> sh;
    b = rgb[3:0] >> sh;
    return {r, g, b};
  endfunction

  assign start_edge   = start_btn & ~start_q;
  assign restart_edge = restart_btn & ~restart_q;

  // The blink boundary is judged on the frame about to complete, hence +1;
  // widened so the saturated count 255 still maps to 256.
  assign cnt_plus1 = {1'b0, frame_cnt_q} + 9'd1;
  assign blink_hit = (cnt_plus1 % BlinkLen) == 9'd0;

  // Dim amount applied to the live image while dying.
`ifdef SCREEN_FADE_EN
  logic [7:0] fade_level;
  assign fade_level = frame_cnt_q / 8'(FADE_STEP);
  assign dim_shift  = (fade_level > 8'd3) ? 2'd3 : fade_level[1:0];
`else
  assign dim_shift = 2'd1;
`endif

  // Next-state, frame counter, blink and clear-request logic.
  always_comb begin
    state_d     = state_q;
    blink_d     = blink_q;
    clear_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      StTitle: begin
        if (start_edge) begin
          state_d = StPlay;
          clear_d = 1'b1;
        end
      end
      StPlay: begin
        if (player_dead) begin
          state_d = StDying;
        end
      end
      StDying: begin
        if (frame_start && (frame_cnt_q == DeathLast)) begin
          state_d = StOver;
          blink_d = 1'b0;
        end
      end
      StOver: begin
        if (frame_start && blink_hit) begin
          blink_d = ~blink_q;
        end
        // Early restart edges are simply dropped: the edge is gone next cycle.
        if (restart_edge && (frame_cnt_q >= HoldMin)) begin
          state_d = StTitle;
          clear_d = 1'b1;
        end
      end
      default: state_d = StTitle;
    endcase

    // A state change restarts frame timing, even if a frame_start coincides.
    if (state_d != state_q) begin
      frame_cnt_d = 8'd0;
    end else if (frame_start && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Pixel source arbitration for the current screen.
  always_comb begin
    rgb_d = 12'h000;
    unique case (state_q)
      StTitle: rgb_d = pix.title_on ? pix.title_rgb : 12'h000;
      StPlay:  rgb_d = pix.game_rgb;
      StDying: rgb_d = dim_rgb(pix.game_rgb, dim_shift);
      StOver:  rgb_d = (pix.gameover_on && !blink_q) ? pix.gameover_rgb
                                                    : dim_rgb(pix.game_rgb, 2'd2);
      default: rgb_d = 12'h000;
    endcase
  end

  // State, counters, button history and registered outputs.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q     <= StTitle;
      frame_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
      start_q     <= 1'b0;
      restart_q   <= 1'b0;
      clear_q     <= 1'b0;
      active_q    <= 1'b0;
      rgb_q       <= 12'h000;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      start_q     <= start_btn;
      restart_q   <= restart_btn;
      clear_q     <= clear_d;
      active_q    <= (state_d == StPlay);
      rgb_q       <= rgb_d;
    end
  end

  assign state       = state_q;
  assign game_active = active_q;
  assign clear_game  = clear_q;
  assign pix.red     = rgb_q[11:8];
  assign pix.green   = rgb_q[7:4];
  assign pix.blue    = rgb_q[3:0];

endmodule

// File: doc/screen_state_sequencer.md
Name: screen_state_sequencer

Overview:
- Top-level screen/overlay controller for the VGA pipeline.
- Sequences the game through four screens: title, play, dying and game-over. It counts frames to time transitions and blink.
- Arbitrates which source drives the pixel each cycle: title sprite, game-over sprite, or live game image.
- Sits between the sprite ROM/palette blocks (pixel plus "on" flag) and the VGA output.

Parameters:
- DEATH_FRAMES, 60, frames spent in DYING before OVER (1..255).
- BLINK_FRAMES, 30, half-period in frames of the game-over overlay blink (1..255).
- HOLD_FRAMES, 90, frames in OVER before restart is accepted (0..255).
- FADE_STEP, 15, frames per dim step (used only with FADE_EN).

Ports:
- vga_clk  in  1  pixel clock; all state on posedge.
- reset_n  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at DrawX=0, DrawY=0.
- start_btn  in  1  level; rising edge starts a game.
- restart_btn  in  1  level; rising edge returns to title.
- player_dead  in  1  level from game logic.
- game_rgb  in  12  live game pixel {r[3:0],g[3:0],b[3:0]}.
- title_rgb  in  12  title sprite palette output.
- title_on  in  1  title sprite covers current pixel.
- gameover_rgb  in  12  game-over sprite palette output.
- gameover_on  in  1  game-over sprite covers current pixel.
- red, green, blue  out  4 each  registered output pixel.
- state  out  2  0=TITLE, 1=PLAY, 2=DYING, 3=OVER.
- game_active  out  1  high only in PLAY.
- clear_game  out  1  one-cycle pulse requesting a game-logic reset.

Behaviour:
- Reset (reset_n=0 at posedge) forces the following; reset mid-frame or mid-state takes effect on the next edge:
  - state=TITLE, frame_cnt=0, blink=0, button edge registers=0.
  - red/green/blue=0, clear_game=0, game_active=0.
- Button edges:
  - start_btn and restart_btn each go through a registered previous-value flop.
  - edge = btn & ~btn_q, so each edge is a one-cycle event.
  - A held button never retriggers.
- frame_cnt is 8-bit:
  - Increments on frame_start and saturates at 255.
  - Clears to 0 on every state transition. A transition has priority over a simultaneous frame_start.
- TITLE:
  - start edge -> PLAY, with clear_game=1 for exactly that next cycle.
  - player_dead and restart are ignored.
- PLAY:
  - player_dead=1 -> DYING on the next edge.
  - Buttons are ignored.
- DYING: at frame_start with frame_cnt==DEATH_FRAMES-1 -> OVER, with blink cleared to 0.
- OVER:
  - blink toggles at every frame_start where (frame_cnt+1) is a multiple of BLINK_FRAMES.
  - restart edge with frame_cnt>=HOLD_FRAMES -> TITLE, with clear_game=1 for one cycle.
  - A restart edge earlier than that is discarded, not queued.
- Pixel select (combinational, then registered), giving 1-cycle latency from input pixel to red/green/blue:
  - TITLE: title_on ? title_rgb : 12'h000.
  - PLAY: game_rgb.
  - DYING: game_rgb dimmed, each 4-bit channel >>1.
  - OVER: (gameover_on & ~blink) ? gameover_rgb : (game_rgb with each channel >>2).
- Outputs:
  - state and game_active are registered and reflect the current state.
  - clear_game is registered and asserted the cycle after the transition edge.

Optional Feature:
- Macro: SCREEN_FADE_EN.
- Defined: DYING dim shift = min(frame_cnt / FADE_STEP, 3), so the image fades progressively: 0, 1, 2, then a 3-bit right shift per channel.
- Undefined: fixed shift of 1 throughout DYING; FADE_STEP is unused.

Test Plan:
- Reset then start pulse: reset_n=0 for 2 cycles; then start_btn 0->1 -> state=1, clear_game high exactly 1 cycle, game_active=1.
- Title arbitration: title_on=1, title_rgb=12'hABC, then title_on=0 -> red/green/blue=A,B,C one cycle after, then 0,0,0.
- Death timing (DEATH_FRAMES=4): in PLAY set player_dead=1 -> state=2; after exactly 4 frame_start pulses, state=3. Meanwhile game_rgb=12'hFFF -> output 7,7,7.
- Blink (BLINK_FRAMES=2, gameover_on=1, gameover_rgb=12'h123, game_rgb=12'h888): output 1,2,3 for frames 0-1, then 2,2,2 for frames 2-3, repeating.
- Hold gating (HOLD_FRAMES=3): restart edge at frame_cnt=1 -> remains OVER, no clear_game; restart edge at frame_cnt=3 -> state=0, clear_game pulse.
- Simultaneity and reset: a start edge coincident with frame_start -> frame_cnt=0 in PLAY. reset_n=0 asserted in DYING -> state=0, rgb=0 next cycle.
- SCREEN_FADE_EN build (FADE_STEP=2, game_rgb=12'hFFF): DYING output F, 7, 3, 1 per channel at frame_cnt 0, 2, 4, 6.
